// File: rtl/tag_match_pipe_if.sv
// Request/response bundle between the tag-array read port, the tag comparator
// and the cache controller FSM.
interface tag_match_pipe_if #(
    parameter int TAG_W = 8,
    parameter int WAYS  = 4
);
    localparam int IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    logic                    req_valid;
    logic                    req_ready;
    logic [TAG_W-1:0]        req_tag;
    logic [WAYS*TAG_W-1:0]   way_tags;
    logic [WAYS-1:0]         way_valid;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic                    rsp_hit;
    logic [IDX_W-1:0]        rsp_way;
    logic                    rsp_multi_hit;
    logic [WAYS-1:0]         rsp_match_vec;

    modport master (
        output req_valid, req_tag, way_tags, way_valid, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_multi_hit, rsp_match_vec
    );

    modport slave (
        input  req_valid, req_tag, way_tags, way_valid, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_multi_hit, rsp_match_vec
    );
endinterface

// File: rtl/tag_match_pipe.sv
// Two-stage N-way tag comparator: stage 1 registers the qualified match vector,
// stage 2 resolves hit / lowest way / multi-hit. Saturating hit/miss counters.
module tag_match_pipe #(
    parameter int TAG_W = 8,
    parameter int WAYS  = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    tag_match_pipe_if.slave   bus,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic                r_s1_valid;
    logic [WAYS-1:0]     r_s1_match;
    logic                r_rsp_valid;
    logic                r_rsp_hit;
    logic [IDX_W-1:0]    r_rsp_way;
    logic                r_rsp_multi;
    logic [WAYS-1:0]     r_rsp_vec;
    logic [CNT_W-1:0]    r_hit_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;

    logic                w_s2_en;
    logic                w_req_ready;
    logic                w_rsp_fire;
    logic [WAYS-1:0]     w_match;
    logic [IDX_W-1:0]    w_way;
    logic                w_multi;

    assign w_s2_en     = !r_rsp_valid || bus.rsp_ready;
    assign w_req_ready = !r_s1_valid || w_s2_en;
    assign w_rsp_fire  = r_rsp_valid && bus.rsp_ready;

    // Per-bit XNOR reduced by AND, qualified with the way's valid bit.
    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
            assign w_match[gi] = bus.way_valid[gi]
                               & (&(bus.req_tag ~^ bus.way_tags[gi*TAG_W +: TAG_W]));
        end
    endgenerate

    // Lowest set bit wins the way index; any later set bit flags a multi-hit.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        w_way   = '0;
        w_multi = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (r_s1_match[i]) begin
                if (seen) w_multi = 1'b1;
                else      w_way   = IDX_W'(i);
                seen = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_match <= '0;
        end else if (w_req_ready) begin
            r_s1_valid <= bus.req_valid;
            if (bus.req_valid) r_s1_match <= w_match;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_way   <= '0;
            r_rsp_multi <= 1'b0;
            r_rsp_vec   <= '0;
        end else if (w_s2_en) begin
            r_rsp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rsp_hit   <= |r_s1_match;
                r_rsp_way   <= w_way;
                r_rsp_multi <= w_multi;
                r_rsp_vec   <= r_s1_match;
            end
        end
    end

    // Clear takes priority over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (stat_clr) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_rsp_fire) begin
            if (r_rsp_hit && r_hit_cnt != CNT_MAX)
                r_hit_cnt <= r_hit_cnt + 1'b1;
            if (!r_rsp_hit && r_miss_cnt != CNT_MAX)
                r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign bus.req_ready     = w_req_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_hit       = r_rsp_hit;
    assign bus.rsp_way       = r_rsp_way;
    assign bus.rsp_multi_hit = r_rsp_multi;
    assign bus.rsp_match_vec = r_rsp_vec;
    assign hit_cnt           = r_hit_cnt;
    assign miss_cnt          = r_miss_cnt;
endmodule

// File: tb/tb_tag_match_pipe.sv
// Directed bench for tag_match_pipe: a CNT_W=16 instance plus a CNT_W=2 twin
// fed identical stimulus for the saturation checks.
module tb_tag_match_pipe;
    logic        clk;
    logic        rst_n;
    logic        stat_clr;
    logic [15:0] hit_cnt, miss_cnt;
    logic [1:0]  s_hit_cnt, s_miss_cnt;
    int          n_vec;
    int          n_miscmp;

    tag_match_pipe_if #(.TAG_W(8), .WAYS(4)) bus ();
    tag_match_pipe_if #(.TAG_W(8), .WAYS(4)) bus_s ();

    assign bus_s.req_valid = bus.req_valid;
    assign bus_s.req_tag   = bus.req_tag;
    assign bus_s.way_tags  = bus.way_tags;
    assign bus_s.way_valid = bus.way_valid;
    assign bus_s.rsp_ready = bus.rsp_ready;

    tag_match_pipe #(.TAG_W(8), .WAYS(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .stat_clr(stat_clr),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    tag_match_pipe #(.TAG_W(8), .WAYS(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus_s), .stat_clr(stat_clr),
        .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    // One request with rsp_ready high; optionally pulse stat_clr on the response handshake.
    task automatic single(input string nm, input logic [7:0] t, input logic [31:0] tags,
                          input logic [3:0] v, input logic eh, input logic [1:0] ew,
                          input logic em, input logic [3:0] evec, input logic clr);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_tag = t; bus.way_tags = tags; bus.way_valid = v;
        bus.rsp_ready = 1'b1;
        #1 chk({nm, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_tag = ~t; bus.way_tags = ~tags; bus.way_valid = ~v;
        chk({nm, "_lat1_valid"}, 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        chk({nm, "_hit"},   32'(bus.rsp_hit), 32'(eh));
        chk({nm, "_way"},   32'(bus.rsp_way), 32'(ew));
        chk({nm, "_multi"}, 32'(bus.rsp_multi_hit), 32'(em));
        chk({nm, "_vec"},   32'(bus.rsp_match_vec), 32'(evec));
        stat_clr = clr;
        @(negedge clk);
        stat_clr = 1'b0;
        chk({nm, "_drained"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    logic [7:0] st_tag  [4];
    logic [1:0] st_way  [4];
    logic       st_hit  [4];
    logic [3:0] st_vec  [4];
    int         idx, got;
    logic       rdy, v_s, stale;

    initial begin
        n_vec = 0; n_miscmp = 0;
        rst_n = 1'b0; stat_clr = 1'b0;
        bus.req_valid = 1'b0; bus.req_tag = '0; bus.way_tags = '0; bus.way_valid = '0;
        bus.rsp_ready = 1'b0;
        st_tag = '{8'h11, 8'h22, 8'h44, 8'h99};
        st_way = '{2'd0, 2'd1, 2'd3, 2'd0};
        st_hit = '{1'b1, 1'b1, 1'b1, 1'b0};
        st_vec = '{4'b0001, 4'b0010, 4'b1000, 4'b0000};

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_hit",       32'(bus.rsp_hit), 32'd0);
        chk("rst_way",       32'(bus.rsp_way), 32'd0);
        chk("rst_multi",     32'(bus.rsp_multi_hit), 32'd0);
        chk("rst_vec",       32'(bus.rsp_match_vec), 32'd0);
        chk("rst_hit_cnt",   32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt",  32'(miss_cnt), 32'd0);
        rst_n = 1'b1;
        #1 chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        single("hit1",  8'h33, 32'h44332211, 4'b1111, 1'b1, 2'd2, 1'b0, 4'b0100, 1'b0);
        chk("hit1_hit_cnt",  32'(hit_cnt), 32'd1);
        chk("hit1_miss_cnt", 32'(miss_cnt), 32'd0);
        single("inval", 8'h33, 32'h44332211, 4'b1011, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        chk("inval_miss_cnt", 32'(miss_cnt), 32'd1);
        single("miss",  8'h55, 32'h44332211, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        chk("miss_miss_cnt", 32'(miss_cnt), 32'd2);
        single("multi", 8'hAA, 32'hAAAA5AAA, 4'b1111, 1'b1, 2'd0, 1'b1, 4'b1101, 1'b0);
        chk("multi_hit_cnt", 32'(hit_cnt), 32'd2);

        // Backpressure: only two requests fit while the consumer stalls.
        @(negedge clk);
        bus.way_tags = 32'h44332211; bus.way_valid = 4'b1111; bus.rsp_ready = 1'b0;
        idx = 0; got = 0;
        for (int c = 0; c < 4; c++) begin
            bus.req_valid = 1'b1; bus.req_tag = st_tag[idx];
            #1 rdy = bus.req_ready;
            @(posedge clk);
            if (rdy) idx++;
            @(negedge clk);
            if (c == 2) chk("stall_vec_c2", 32'(bus.rsp_match_vec), 32'b0001);
        end
        chk("stall_accepts",   32'(idx), 32'd2);
        chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
        chk("stall_valid",     32'(bus.rsp_valid), 32'd1);
        chk("stall_hit",       32'(bus.rsp_hit), 32'd1);
        chk("stall_vec",       32'(bus.rsp_match_vec), 32'b0001);

        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (idx < 4) begin
                bus.req_valid = 1'b1; bus.req_tag = st_tag[idx];
            end else begin
                bus.req_valid = 1'b0;
            end
            #1;
            rdy = bus.req_ready; v_s = bus.rsp_valid;
            if (v_s && got < 4) begin
                chk($sformatf("stream%0d_hit", got), 32'(bus.rsp_hit), 32'(st_hit[got]));
                chk($sformatf("stream%0d_way", got), 32'(bus.rsp_way), 32'(st_way[got]));
                chk($sformatf("stream%0d_vec", got), 32'(bus.rsp_match_vec), 32'(st_vec[got]));
            end
            @(posedge clk);
            if (rdy && idx < 4) idx++;
            if (v_s) got++;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        chk("stream_count",     32'(got), 32'd4);
        chk("stream_no_dup",    32'(bus.rsp_valid), 32'd0);
        chk("stream_hit_cnt",   32'(hit_cnt), 32'd5);
        chk("stream_miss_cnt",  32'(miss_cnt), 32'd3);
        chk("sat_hit_cnt",      32'(s_hit_cnt), 32'd3);
        chk("sat_miss_cnt",     32'(s_miss_cnt), 32'd3);

        single("clr", 8'h22, 32'h44332211, 4'b1111, 1'b1, 2'd1, 1'b0, 4'b0010, 1'b1);
        chk("clr_hit_cnt",      32'(hit_cnt), 32'd0);
        chk("clr_miss_cnt",     32'(miss_cnt), 32'd0);
        chk("clr_sat_hit_cnt",  32'(s_hit_cnt), 32'd0);
        single("after_clr", 8'h44, 32'h44332211, 4'b1111, 1'b1, 2'd3, 1'b0, 4'b1000, 1'b0);
        chk("after_clr_hit_cnt", 32'(hit_cnt), 32'd1);

        // Two requests in flight, then an asynchronous reset mid-cycle.
        @(negedge clk);
        bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_tag = 8'h11;
        @(negedge clk);
        bus.req_tag = 8'h22;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("inflight_valid",     32'(bus.rsp_valid), 32'd1);
        chk("inflight_req_ready", 32'(bus.req_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_hit_cnt",   32'(hit_cnt), 32'd0);
        chk("arst_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1; bus.rsp_ready = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            stale = stale | bus.rsp_valid;
        end
        chk("arst_no_stale",       32'(stale), 32'd0);
        chk("arst_post_req_ready", 32'(bus.req_ready), 32'd1);
        chk("arst_post_miss_cnt",  32'(miss_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
